// File: rtl/dds_signal_generator_if.sv
// Signal bundle between the DDS generator, its sine ROM and the key/switch front panel.
// master = generator side, slave = environment (keys, switch, ROM) side.
interface dds_signal_generator_if #(
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 8,
  parameter int FREQ_W = 16
);
  logic [1:0]        switch;
  logic              freq_add;
  logic              freq_dec;
  logic [OUT_W-1:0]  rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [FREQ_W-1:0] freq_word;
  logic [OUT_W-1:0]  wave_out;

  modport master (
    input  switch, freq_add, freq_dec, rom_data,
    output rom_addr, freq_word, wave_out
  );

  modport slave (
    output switch, freq_add, freq_dec, rom_data,
    input  rom_addr, freq_word, wave_out
  );
endinterface

// File: rtl/dds_signal_generator.sv
// DDS waveform generator: key-stepped tuning word, phase accumulator, sine/square/triangle/saw.
// Optional key debouncing is enabled by defining SIGGEN_DEBOUNCE_EN.
module dds_signal_generator #(
  parameter int PHASE_W      = 24,
  parameter int FREQ_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int OUT_W        = 8,
  parameter int FREQ_INIT    = 16,
  parameter int FREQ_STEP    = 16,
  parameter int FREQ_MIN     = 16,
  parameter int FREQ_MAX     = 4096,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  dds_signal_generator_if.master bus
);

  localparam logic [FREQ_W:0]   STEP_X = (FREQ_W+1)'(FREQ_STEP);
  localparam logic [FREQ_W:0]   MIN_X  = (FREQ_W+1)'(FREQ_MIN);
  localparam logic [FREQ_W:0]   MAX_X  = (FREQ_W+1)'(FREQ_MAX);
  localparam logic [FREQ_W-1:0] INIT_W = FREQ_W'(FREQ_INIT);

  // Bit order in the synchroniser: [3:2] switch, [1] freq_dec, [0] freq_add
  logic [3:0]        sync_meta_reg;
  logic [3:0]        sync_reg;
  logic [1:0]        key_level;
  logic [1:0]        key_prev_reg;
  logic [1:0]        key_rise;
  logic [FREQ_W-1:0] freq_word_reg;
  logic [FREQ_W-1:0] freq_next;
  logic [FREQ_W:0]   freq_sum;
  logic [PHASE_W-1:0] acc_reg;
  logic [PHASE_W-1:0] acc_next;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [OUT_W:0]    phase_d_reg;
  logic [OUT_W-1:0]  wave_reg;
  logic [OUT_W-1:0]  wave_next;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sync_meta_reg <= '0;
      sync_reg      <= '0;
    end else begin
      sync_meta_reg <= {bus.switch, bus.freq_dec, bus.freq_add};
      sync_reg      <= sync_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
`ifdef SIGGEN_DEBOUNCE_EN
      localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;

      // Level flips only once the synchronised key has disagreed with it for DEBOUNCE_CYC cycles
      always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (sync_reg[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
          cnt_reg   <= '0;
          level_reg <= sync_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign key_level[gi] = level_reg;
`else
      assign key_level[gi] = sync_reg[gi];
`endif
    end
  endgenerate

  assign key_rise = key_level & ~key_prev_reg;

  // Saturating step in FREQ_W+1 bits; simultaneous add/dec presses cancel out
  always_comb begin
    freq_next = freq_word_reg;
    freq_sum  = {1'b0, freq_word_reg} + STEP_X;
    if (key_rise == 2'b01) begin
      freq_next = (freq_sum > MAX_X) ? MAX_X[FREQ_W-1:0] : freq_sum[FREQ_W-1:0];
    end else if (key_rise == 2'b10) begin
      freq_next = ({1'b0, freq_word_reg} < (MIN_X + STEP_X)) ? MIN_X[FREQ_W-1:0]
                                                             : freq_word_reg - STEP_X[FREQ_W-1:0];
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      key_prev_reg  <= '0;
      freq_word_reg <= INIT_W;
    end else begin
      key_prev_reg  <= key_level;
      freq_word_reg <= freq_next;
    end
  end

  assign acc_next = acc_reg + PHASE_W'(freq_word_reg);

  // Non-sine modes use a delayed copy of the phase so they line up with the ROM read latency
  always_comb begin
    wave_next = wave_reg;
    case (sync_reg[3:2])
      2'b00:   wave_next = bus.rom_data;
      2'b01:   wave_next = phase_d_reg[OUT_W] ? '0 : '1;
      2'b10:   wave_next = phase_d_reg[OUT_W] ? ~phase_d_reg[OUT_W-1:0] : phase_d_reg[OUT_W-1:0];
      default: wave_next = phase_d_reg[OUT_W -: OUT_W];
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      acc_reg      <= '0;
      rom_addr_reg <= '0;
      phase_d_reg  <= '0;
      wave_reg     <= '0;
    end else begin
      acc_reg      <= acc_next;
      rom_addr_reg <= acc_next[PHASE_W-1 -: ADDR_W];
      phase_d_reg  <= acc_reg[PHASE_W-1 -: OUT_W+1];
      wave_reg     <= wave_next;
    end
  end

  assign bus.rom_addr  = rom_addr_reg;
  assign bus.freq_word = freq_word_reg;
  assign bus.wave_out  = wave_reg;

endmodule

// File: tb/tb_dds_signal_generator.sv
// Directed bench for dds_signal_generator: reset, all four waveforms, key stepping/saturation,
// async mid-run reset and (with SIGGEN_DEBOUNCE_EN) glitch rejection.
module tb_dds_signal_generator;

  localparam int PHASE_W = 10;
  localparam int FREQ_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int OUT_W   = 8;
`ifdef SIGGEN_DEBOUNCE_EN
  localparam int HOLD = 20;
`else
  localparam int HOLD = 4;
`endif

  logic sys_clk = 1'b0;
  logic reset   = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 sys_clk = ~sys_clk;

  dds_signal_generator_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .FREQ_W(FREQ_W)) bus ();

  dds_signal_generator #(
    .PHASE_W(PHASE_W), .FREQ_W(FREQ_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W),
    .FREQ_INIT(4), .FREQ_STEP(4), .FREQ_MIN(4), .FREQ_MAX(16), .DEBOUNCE_CYC(8)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  // Synchronous sine ROM stand-in: data = addr ^ 0x5A, one cycle after the address
  always @(posedge sys_clk) bus.rom_data <= bus.rom_addr ^ 8'h5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Async reset assertion mid-cycle, release 1 time unit after an edge (next edge = cycle 1)
  task automatic do_reset(input logic [1:0] sw);
    @(posedge sys_clk);
    #3;
    reset      = 1'b0;
    bus.switch = sw;
    repeat (3) @(posedge sys_clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic press(input logic a, input logic d, input int exp);
    bus.freq_add = a;
    bus.freq_dec = d;
    repeat (HOLD) tick();
    bus.freq_add = 1'b0;
    bus.freq_dec = 1'b0;
    repeat (HOLD) tick();
    check("freq_word_step", 32'(bus.freq_word), 32'(exp));
    $display("key add=%0b dec=%0b -> freq_word=%0d (expect %0d)", a, d, bus.freq_word, exp);
  endtask

  initial begin
    int p;
    int t;
    int add_exp[5] = '{8, 12, 16, 16, 16};
    int dec_exp[5] = '{12, 8, 4, 4, 4};

    bus.switch   = 2'b11;
    bus.freq_add = 1'b0;
    bus.freq_dec = 1'b0;
    repeat (3) tick();
    check("reset_wave", 32'(bus.wave_out), 32'd0);
    check("reset_freq", 32'(bus.freq_word), 32'd4);
    check("reset_addr", 32'(bus.rom_addr), 32'd0);
    $display("reset state: wave=%0d freq=%0d addr=%0d", bus.wave_out, bus.freq_word, bus.rom_addr);
    reset = 1'b1;

    // Sawtooth, then phase-continuous switch to square after cycle 300
    for (int k = 1; k <= 560; k++) begin
      tick();
      p = (4 * (k - 2)) % 1024;
      if (k >= 3 && k <= 302) check("saw", 32'(bus.wave_out), 32'((k - 2) % 256));
      if (k >= 303) check("square", 32'(bus.wave_out), (p >= 512) ? 32'd0 : 32'd255);
      if (k == 300) bus.switch = 2'b01;
    end
    $display("saw/square run done: checks=%0d bad=%0d", total, bad);

    do_reset(2'b10);
    for (int k = 1; k <= 300; k++) begin
      tick();
      p = (4 * (k - 2)) % 1024;
      t = (p >> 1) & 255;
      if (k >= 3) check("triangle", 32'(bus.wave_out), (p >= 512) ? 32'((~t) & 255) : 32'(t));
    end
    $display("triangle run done: checks=%0d bad=%0d", total, bad);

    do_reset(2'b00);
    for (int k = 1; k <= 300; k++) begin
      tick();
      check("rom_addr", 32'(bus.rom_addr), 32'(k % 256));
      if (k >= 3) check("sine", 32'(bus.wave_out), 32'(((k - 2) % 256) ^ 8'h5A));
    end
    $display("sine run done: checks=%0d bad=%0d", total, bad);

    do_reset(2'b11);
    repeat (5) tick();
    check("freq_after_reset", 32'(bus.freq_word), 32'd4);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, add_exp[i]);
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, dec_exp[i]);
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b1, 8);

    // Asynchronous reset mid-run: outputs must clear without a clock edge
    @(posedge sys_clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_wave", 32'(bus.wave_out), 32'd0);
    check("midrst_freq", 32'(bus.freq_word), 32'd4);
    check("midrst_addr", 32'(bus.rom_addr), 32'd0);
    $display("mid-run reset: wave=%0d freq=%0d addr=%0d", bus.wave_out, bus.freq_word, bus.rom_addr);
    repeat (2) @(posedge sys_clk);
    #1;
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k >= 3) check("saw_after_rst", 32'(bus.wave_out), 32'(k - 2));
    end

`ifdef SIGGEN_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) begin
      bus.freq_add = 1'b1;
      repeat (3) tick();
      bus.freq_add = 1'b0;
      repeat (12) tick();
    end
    check("glitch_no_step", 32'(bus.freq_word), 32'd4);
    $display("glitches: freq_word=%0d (expect 4)", bus.freq_word);
    press(1'b1, 1'b0, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
